// File: rtl/count_connected_feeder.sv
// count_connected_feeder
//   Input-side driver for the pipelined connected-component counting core.
//   Pops one job from a show-ahead FIFO per accepted core request. Replays the
//   job to the core DATA_IN_LATENCY cycles later, and replays its starting
//   connect count a further STARTING_CONNECT_COUNT_LAG cycles on. Also tracks
//   how many graphs are in flight inside the core.
//
//   Optional feature macro: COUNT_CONNECTED_FEEDER_STATS_EN
//     defined     -> graphsIssued / resultsReceived are live 32-bit counters
//     not defined -> both outputs are tied to zero
module count_connected_feeder #(
    parameter int unsigned EXTRA_DATA_WIDTH           = 10,
    parameter int unsigned DATA_IN_LATENCY            = 4,
    parameter int unsigned STARTING_CONNECT_COUNT_LAG = 3,
    parameter int unsigned OUTSTANDING_WIDTH          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coreRequest,
    input  logic                         coreDone,
    input  logic                         jobValid,
    input  logic [127:0]                 jobGraph,
    input  logic [5:0]                   jobConnectCount,
    input  logic [EXTRA_DATA_WIDTH-1:0]  jobExtraData,
    output logic                         jobPop,
    output logic                         start,
    output logic [127:0]                 graphOut,
    output logic [EXTRA_DATA_WIDTH-1:0]  extraDataOut,
    output logic [5:0]                   startingConnectCountOut_DELAYED,
    output logic [OUTSTANDING_WIDTH-1:0] inFlight,
    output logic                         idle,
    output logic [31:0]                  graphsIssued,
    output logic [31:0]                  resultsReceived
);

    localparam int unsigned L = DATA_IN_LATENCY;
    localparam int unsigned G = STARTING_CONNECT_COUNT_LAG;

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------

    // A request is accepted only when the FIFO has a job. A request that
    // finds the FIFO empty is dropped, and the core re-requests later.
    always_comb begin
        jobPop = coreRequest & jobValid & ~rst;
    end

    // ------------------------------------------------------------------
    // Issue delay line (stage 0 here is the stage written in the pop cycle)
    // ------------------------------------------------------------------
    logic                        iv_q [L];
    logic [127:0]                ig_q [L];
    logic [5:0]                  ic_q [L];
    logic [EXTRA_DATA_WIDTH-1:0] ie_q [L];

    // Valid bits shift every cycle; reset clears them so a job that was
    // already popped is discarded instead of issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < L; s++) begin
                iv_q[s] <= 1'b0;
            end
        end else begin
            iv_q[0] <= jobPop;
            for (int unsigned s = 1; s < L; s++) begin
                iv_q[s] <= iv_q[s-1];
            end
        end
    end

    // Payload shifts alongside the valids. It has no reset because every
    // consumer gates it with the matching valid.
    always_ff @(posedge clk) begin
        ig_q[0] <= jobGraph;
        ic_q[0] <= jobConnectCount;
        ie_q[0] <= jobExtraData;
        for (int unsigned s = 1; s < L; s++) begin
            ig_q[s] <= ig_q[s-1];
            ic_q[s] <= ic_q[s-1];
            ie_q[s] <= ie_q[s-1];
        end
    end

    // Last issue stage drives the core. Data reads as zero when no job is issued.
    always_comb begin
        start        = iv_q[L-1];
        graphOut     = iv_q[L-1] ? ig_q[L-1] : '0;
        extraDataOut = iv_q[L-1] ? ie_q[L-1] : '0;
    end

    // Any job still travelling the issue line keeps the feeder busy.
    logic issue_busy;

    // OR-reduce the issue-line valids.
    always_comb begin
        issue_busy = 1'b0;
        for (int unsigned s = 0; s < L; s++) begin
            issue_busy = issue_busy | iv_q[s];
        end
    end

    // ------------------------------------------------------------------
    // Starting connect count delay line
    // ------------------------------------------------------------------
    logic count_busy;

    if (G > 0) begin : g_count_line
        logic       cv_q [G];
        logic [5:0] cc_q [G];

        // Count valids follow start. Reset clears them like the issue line.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned s = 0; s < G; s++) begin
                    cv_q[s] <= 1'b0;
                end
            end else begin
                cv_q[0] <= start;
                for (int unsigned s = 1; s < G; s++) begin
                    cv_q[s] <= cv_q[s-1];
                end
            end
        end

        // Count payload, gated by valid at the output.
        always_ff @(posedge clk) begin
            cc_q[0] <= ic_q[L-1];
            for (int unsigned s = 1; s < G; s++) begin
                cc_q[s] <= cc_q[s-1];
            end
        end

        // Drive the delayed count and its contribution to busy.
        always_comb begin
            startingConnectCountOut_DELAYED = cv_q[G-1] ? cc_q[G-1] : '0;
            count_busy = 1'b0;
            for (int unsigned s = 0; s < G; s++) begin
                count_busy = count_busy | cv_q[s];
            end
        end
    end else begin : g_count_direct
        // With zero lag, the count rides alongside start.
        always_comb begin
            startingConnectCountOut_DELAYED = start ? ic_q[L-1] : '0;
            count_busy = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracking
    // ------------------------------------------------------------------
    logic [OUTSTANDING_WIDTH-1:0] inflight_q;
    logic [OUTSTANDING_WIDTH-1:0] inflight_d;
    logic                         done_counted;

    // A completion is counted only while something is outstanding. This
    // absorbs stray done pulses, for example from before reset.
    always_comb begin
        done_counted = coreDone & ~rst & (inflight_q != '0);
        inflight_d   = inflight_q;
        if (start && !done_counted) begin
            if (inflight_q != '1) begin
                inflight_d = inflight_q + OUTSTANDING_WIDTH'(1);
            end
        end else if (done_counted && !start) begin
            inflight_d = inflight_q - OUTSTANDING_WIDTH'(1);
        end
    end

    // In-flight register.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Expose the count and the drain-complete flag.
    always_comb begin
        inFlight = inflight_q;
        idle     = (inflight_q == '0) & ~issue_busy & ~count_busy & ~jobValid;
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef COUNT_CONNECTED_FEEDER_STATS_EN
    logic [31:0] issued_q;
    logic [31:0] received_q;

    // Free-running, wrapping counters of issued graphs and counted completions.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q   <= '0;
            received_q <= '0;
        end else begin
            if (start) begin
                issued_q <= issued_q + 32'd1;
            end
            if (done_counted) begin
                received_q <= received_q + 32'd1;
            end
        end
    end

    // Drive the statistics outputs.
    always_comb begin
        graphsIssued    = issued_q;
        resultsReceived = received_q;
    end
`else
    // Statistics disabled: outputs read as constant zero.
    always_comb begin
        graphsIssued    = '0;
        resultsReceived = '0;
    end
`endif

endmodule
